// File: rtl/oscilo_pkg.sv
// oscilo_pkg: shared types and defaults for the capture sampler and reader
package oscilo_pkg;
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} reader_state_t;
    localparam int SAMPLE_W         = 8;
    localparam int DEF_SAMPLE_DEPTH = 8;
    localparam int DEF_PRE_SAMPLES  = 128;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small synchronous FIFO with flush; head is visible combinationally
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                    clk_50mhz,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign do_pop = pop & ~empty;
    assign empty  = count == '0;
    assign full   = count == (AW+1)'(DEPTH);
    assign dout   = mem[rd_ptr];

    // storage, pointers and occupancy; a flush only resets the bookkeeping
    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/capture_reader.sv
// capture_reader: streams the circular capture buffer out oldest-first
module capture_reader
    import oscilo_pkg::*;
#(
    parameter int SAMPLE_DEPTH = DEF_SAMPLE_DEPTH,
    parameter int PRE_SAMPLES  = DEF_PRE_SAMPLES,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                    clk_50mhz,
    input  logic                    reset,
    input  logic                    activate,
    output logic                    done,
    output logic                    busy,
    input  logic [SAMPLE_DEPTH-1:0] offset,
    output logic                    mem_re,
    output logic [SAMPLE_DEPTH-1:0] mem_rd_addr,
    input  logic [SAMPLE_W-1:0]     mem_rd_data,
    output logic [SAMPLE_W-1:0]     out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last
);
    localparam int N  = 1 << SAMPLE_DEPTH;
    localparam int CW = SAMPLE_DEPTH + 1;
    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    reader_state_t           state;
    logic [SAMPLE_DEPTH-1:0] start_addr;
    logic [CW-1:0]           rd_cnt;
    logic [CW-1:0]           tx_cnt;
    logic [CW-1:0]           tx_nxt;
    logic [FW-1:0]           fifo_count;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    pend;
    logic                    pop;
    logic                    abort;
    logic                    credit;

    // a pop in this cycle returns its slot immediately, which keeps a
    // two-entry FIFO at one sample per clock despite the read latency
    assign pop         = out_valid & out_ready;
    assign abort       = (state == STREAM || state == DRAIN) & ~activate;
    assign credit      = fifo_count + FW'(pend) < FW'(FIFO_DEPTH) + FW'(pop);
    assign mem_re      = (state == STREAM) & activate & credit;
    assign mem_rd_addr = start_addr + rd_cnt[SAMPLE_DEPTH-1:0];
    assign tx_nxt      = tx_cnt + CW'(pop);
    assign out_valid   = ~fifo_empty;
    assign out_last    = out_valid & (tx_cnt == CW'(N - 1));

    sync_fifo #(.WIDTH(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .clr       (abort),
        .push      (pend & ~fifo_full),
        .pop       (pop),
        .din       (mem_rd_data),
        .dout      (out_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // transfer sequencing: latch start, count reads and beats, handle abort
    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            start_addr <= '0;
            rd_cnt     <= '0;
            tx_cnt     <= '0;
            pend       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            pend   <= mem_re;
            tx_cnt <= tx_nxt;
            if (mem_re) rd_cnt <= rd_cnt + CW'(1);
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (activate) begin
                        start_addr <= offset - SAMPLE_DEPTH'(PRE_SAMPLES);
                        rd_cnt     <= '0;
                        tx_cnt     <= '0;
                        busy       <= 1'b1;
                        state      <= STREAM;
                    end
                    STREAM: if (mem_re && rd_cnt == CW'(N - 1)) state <= DRAIN;
                    DRAIN: if (tx_nxt == CW'(N)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    DONE: if (!activate) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_capture_reader.sv
// tb_capture_reader: table-driven and randomized checks of capture_reader
module tb_capture_reader;
    logic       clk_50mhz = 1'b0;
    logic       reset     = 1'b0;
    logic       activate  = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] offset    = 8'h00;
    logic [7:0] mem_rd_data = 8'h00;
    logic       done, busy, mem_re, out_valid, out_last;
    logic [7:0] mem_rd_addr, out_data;

    logic [7:0] ram [256];
    logic [7:0] exp_q [$];
    int checks = 0, failures = 0, cyc = 0;
    bit mon_en = 0, hold_pend = 0;
    logic [7:0] hold_data, first_data, last_data, addr0, addr1;
    int beats, reads, first_cyc, last_cyc, first_re_cyc, act_cyc;

    typedef struct {
        logic [7:0] off;
        int         pct;
        int         exp_first;
        int         exp_last;
    } vec_t;
    vec_t vecs [5];

    capture_reader dut (
        .clk_50mhz   (clk_50mhz),
        .reset       (reset),
        .activate    (activate),
        .done        (done),
        .busy        (busy),
        .offset      (offset),
        .mem_re      (mem_re),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last)
    );

    always #10 clk_50mhz = ~clk_50mhz;
    always @(posedge clk_50mhz) cyc <= cyc + 1;
    always @(posedge clk_50mhz) if (mem_re) mem_rd_data <= ram[mem_rd_addr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // stream monitor: scoreboard against the expected queue, stall stability
    always @(negedge clk_50mhz) begin
        if (reset) chk("fifo_no_overflow", int'(dut.pend && dut.fifo_full), 0);
        if (mon_en) begin
            if (mem_re) begin
                if (reads == 0) begin
                    addr0 = mem_rd_addr;
                    first_re_cyc = cyc;
                end
                if (reads == 1) addr1 = mem_rd_addr;
                reads++;
            end
            if (hold_pend) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, hold_data);
            end
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (out_valid && out_ready) begin
                chk("beat_in_range", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("beat_data", out_data, exp_q.pop_front());
                chk("beat_last", out_last, int'(beats == 255));
                if (beats == 0) first_data = out_data;
                last_data = out_data;
                last_cyc = cyc;
                beats++;
                hold_pend = 0;
            end else begin
                hold_pend = out_valid;
                hold_data = out_data;
            end
        end
    end

    task automatic start_xfer(input logic [7:0] off, input int pct);
        mon_en = 0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(ram[(int'(off) - 128 + i) & 255]);
        beats = 0;
        reads = 0;
        first_cyc = -1;
        last_cyc = -1;
        first_re_cyc = -1;
        hold_pend = 0;
        @(posedge clk_50mhz); #1;
        offset = off;
        activate = 1;
        out_ready = ($urandom_range(1, 100) <= pct);
        act_cyc = cyc;
        mon_en = 1;
    endtask

    task automatic run_xfer(input logic [7:0] off, input int pct, input bit scramble,
                            input int exp_first, input int exp_last);
        int done_cyc = -1;
        start_xfer(off, pct);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_50mhz); #1;
            if (c == 0) chk("busy_after_start", busy, 1);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            out_ready = ($urandom_range(1, 100) <= pct);
            if (scramble) offset = 8'($urandom);
        end
        chk("done_reached", int'(done_cyc >= 0), 1);
        chk("beats", beats, 256);
        chk("leftover", exp_q.size(), 0);
        chk("reads", reads, 256);
        chk("done_latency", done_cyc, last_cyc + 1);
        chk("busy_at_done", busy, 0);
        chk("first_addr", addr0, (int'(off) - 128) & 255);
        chk("second_addr", addr1, (int'(off) - 127) & 255);
        chk("first_re_cycle", first_re_cyc, act_cyc + 1);
        chk("first_valid_cycle", first_cyc, act_cyc + 3);
        if (pct == 100) chk("full_rate_span", last_cyc - first_cyc, 255);
        if (exp_first >= 0) begin
            chk("first_sample", first_data, exp_first);
            chk("last_sample", last_data, exp_last);
        end
    endtask

    task automatic end_xfer();
        activate = 0;
        mon_en = 0;
        @(posedge clk_50mhz); #1;
        chk("done_clear", done, 0);
        chk("idle_no_valid", out_valid, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mem_re"}, mem_re, 0);
        chk({tag, "_addr"}, mem_rd_addr, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_data"}, out_data, 0);
    endtask

    initial begin
        int bad;
        vecs[0] = '{8'h40, 100, 'hC0, 'hBF};
        vecs[1] = '{8'h80, 40,  'h00, 'hFF};
        vecs[2] = '{8'h7F, 100, 'hFF, 'hFE};
        vecs[3] = '{8'h80, 100, 'h00, 'hFF};
        vecs[4] = '{8'h00, 70,  'h80, 'h7F};
        for (int i = 0; i < 256; i++) ram[i] = 8'(i);

        repeat (3) @(posedge clk_50mhz);
        #1;
        chk_reset_outputs("reset");
        reset = 1;

        for (int i = 0; i < 5; i++) begin
            run_xfer(vecs[i].off, vecs[i].pct, 0, vecs[i].exp_first, vecs[i].exp_last);
            end_xfer();
        end

        run_xfer(8'h40, 100, 0, 'hC0, 'hBF);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_50mhz); #1;
            bad += int'(!done);
        end
        chk("done_held", bad, 0);
        chk("no_reads_after_done", reads, 256);
        end_xfer();
        run_xfer(8'h40, 100, 0, 'hC0, 'hBF);
        end_xfer();

        start_xfer(8'h40, 100);
        for (int c = 0; c < 200 && beats < 50; c++) begin
            @(posedge clk_50mhz); #1;
        end
        chk("abort_beats", beats, 50);
        activate = 0;
        mon_en = 0;
        @(posedge clk_50mhz); #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_mem_re", mem_re, 0);
        run_xfer(8'h40, 100, 0, 'hC0, 'hBF);
        end_xfer();

        start_xfer(8'h40, 100);
        repeat (20) begin
            @(posedge clk_50mhz); #1;
        end
        mon_en = 0;
        #3;
        reset = 0;
        #1;
        chk_reset_outputs("async_reset");
        activate = 0;
        @(posedge clk_50mhz); #1;
        reset = 1;
        bad = 0;
        repeat (5) begin
            @(posedge clk_50mhz); #1;
            bad += int'(out_valid | busy | done | mem_re);
        end
        chk("post_reset_idle", bad, 0);
        run_xfer(8'h40, 100, 0, 'hC0, 'hBF);
        end_xfer();

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
            run_xfer(8'($urandom), $urandom_range(25, 100), 1, -1, -1);
            end_xfer();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/capture_reader.md
Name: capture_reader

Overview:
- Read-out side of the capture memory.
- After the sampler signals done, this block reads the circular capture buffer back in chronological order, oldest sample first. It un-rotates the buffer around the trigger offset.
- Samples leave on an 8-bit valid/ready stream, consumed by the display/UART path.
- Full throughput of 1 sample/clk when the consumer is always ready. A small prefetch FIFO absorbs the 1-cycle synchronous-read latency.

Parameters:
- SAMPLE_DEPTH, 8, address width; the buffer holds 2^SAMPLE_DEPTH samples.
- PRE_SAMPLES, 128, number of samples stored before the trigger; start address = offset - PRE_SAMPLES.
- FIFO_DEPTH, 2, prefetch FIFO entries (power of 2, >=2).

Ports:
- clk_50mhz  in  1  system clock, rising edge.
- reset  in  1  async, active-low reset (0 = reset).
- activate  in  1  level request; held high for the whole transfer.
- done  out  1  transfer complete; held until activate drops.
- busy  out  1  high while streaming.
- offset  in  SAMPLE_DEPTH  trigger address from the sampler; sampled at start.
- mem_re  out  1  read enable to the capture RAM.
- mem_rd_addr  out  SAMPLE_DEPTH  read address.
- mem_rd_data  in  8  read data, valid the cycle after mem_re.
- out_data  out  8  sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when high together with out_valid.
- out_last  out  1  high with the final (2^SAMPLE_DEPTH-th) sample.

Behaviour:

Reset (asynchronous, reset=0):
- done=0, busy=0, mem_re=0, mem_rd_addr=0, out_valid=0, out_last=0, out_data=0.
- FIFO empty, all counters 0, state IDLE.

FSM, states IDLE, STREAM, DRAIN, DONE:
- IDLE: on an edge with activate=1:
  - latch start_addr = (offset - PRE_SAMPLES) mod 2^SAMPLE_DEPTH.
  - rd_cnt=0, tx_cnt=0, busy=1, go to STREAM.
- STREAM:
  - Issue a read (mem_re=1, mem_rd_addr=start_addr+rd_cnt, wrapping mod 2^SAMPLE_DEPTH) only when FIFO occupancy + in-flight reads < FIFO_DEPTH.
  - rd_cnt++ on each issued read.
  - After 2^SAMPLE_DEPTH reads have been issued, go to DRAIN. rd_cnt is SAMPLE_DEPTH+1 bits wide.
- DRAIN: no reads. When tx_cnt reaches 2^SAMPLE_DEPTH, go to DONE.
- DONE: done=1, busy=0. When activate=0, done=0 and go to IDLE.

Read pipeline and FIFO:
- mem_rd_data is pushed into the FIFO on the cycle after mem_re=1.
- out_valid = FIFO not empty; out_data = FIFO head.
- Pop on out_valid & out_ready; tx_cnt++ on each pop.
- out_last = out_valid & (tx_cnt == 2^SAMPLE_DEPTH-1).
- Simultaneous push and pop in one cycle is legal; occupancy stays the same.
- The FIFO never overflows. The credit rule guarantees this; the bench asserts it.

Latency:
- Activate sampled at edge 0.
- mem_re high in cycle 1.
- First out_valid in cycle 3.
- With out_ready=1 throughout: one sample per cycle; done rises 1 cycle after the out_last handshake.

Backpressure:
- out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- No sample is dropped or duplicated.

Boundaries:
- Address wrap from 2^SAMPLE_DEPTH-1 to 0 is seamless.
- offset == PRE_SAMPLES gives start_addr=0.
- offset changing mid-transfer is ignored.

Abort:
- activate=0 in STREAM or DRAIN: next edge goes to IDLE.
- FIFO flushed, out_valid=0, busy=0, done stays 0.
- Any in-flight read data is discarded.
- out_valid may drop without a handshake only in this abort case.

Reset mid-operation: immediate return to the reset values above, regardless of state.

Decomposition:
- Shared package oscilo_pkg holds:
  - the FSM state enum reader_state_t (IDLE, STREAM, DRAIN, DONE);
  - SAMPLE_W = 8;
  - default SAMPLE_DEPTH and PRE_SAMPLES, shared with the sampler so both agree.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/empty/full/count, async active-low reset).
- Credit logic and the FSM stay in capture_reader.

Test Plan:
- Full-rate read: mem[i]=i, offset=0x40, out_ready=1.
  - Expect out_data 0xC0..0xFF then 0x00..0xBF: 256 beats in 256 consecutive cycles.
  - out_last only on 0xBF; done=1 the next cycle.
- Backpressure: same memory, offset=0x80, out_ready random ~40%.
  - Expect sequence 0x00..0xFF exactly once, in order.
  - Data held stable while stalled; FIFO never overflows (assertion).
- Wrap and start edge: offset=0x7F.
  - First mem_rd_addr=0xFF, second 0x00.
  - First sample 0xFF, last 0xFE.
- Done handshake: keep activate high 10 cycles after out_last.
  - done stays 1, no further mem_re.
  - Drop activate: done=0 next cycle; re-activate gives a fresh identical transfer.
- Abort: drop activate after 50 beats.
  - Next cycle out_valid=0, busy=0, done=0, mem_re=0.
  - Restart streams from start_addr again.
- Async reset: assert reset=0 mid-STREAM between clock edges.
  - All outputs go to reset values immediately.
  - After release, IDLE with no spurious out_valid.
